// File: rtl/hc05_pkg.sv
// hc05_pkg: state encoding, error codes and frame constants shared by the HC-05 command path.
package hc05_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_CMD  = 3'd1,
    GET_ARG  = 3'd2,
    GET_CHK  = 3'd3,
    GET_TAIL = 3'd4
  } hc05_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_TAIL = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] HDR_BYTE_DEF  = 8'hA5;
  localparam logic [7:0] TAIL_BYTE_DEF = 8'h5A;

  localparam logic [7:0] ACK_XOR_MASK   = 8'h80;
  localparam logic [5:0] ACK_ERR_PREFIX = 6'b111011;

endpackage

// File: rtl/hc05_byte_timeout.sv
// hc05_byte_timeout: inter-byte watchdog; counts while enabled, clears on i_clr,
// pulses o_tc on the cycle the count steps onto LIMIT-1 and then restarts from 0.
`default_nettype none

module hc05_byte_timeout #(
  parameter int LIMIT = 240000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(LIMIT);
  // Decoding one count early lets the caller's registered response land on
  // the same edge at which the counter would reach LIMIT-1.
  localparam logic [CW-1:0] C_PRE_TC = CW'(LIMIT - 2);

  logic [CW-1:0] r_cnt;

  assign o_tc = i_en && !i_clr && (r_cnt == C_PRE_TC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hc05_cmd_parser.sv
// hc05_cmd_parser: assembles HDR/CMD/ARG/CHK/TAIL frames from the UART byte stream
// and reports validated commands or errors. Define HC05_CMD_PARSER_ACK_EN for ack bytes.
`default_nettype none

module hc05_cmd_parser
  import hc05_pkg::*;
#(
  parameter int         CLK_FREQ    = 24000000,
  parameter int         TIMEOUT_CYC = 240000,
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter logic [7:0] TAIL_BYTE   = TAIL_BYTE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       cmd_valid,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic [7:0] frame_cnt,
  output logic [7:0] ack_data,
  output logic       ack_vld
);

  if (CLK_FREQ < 1 || TIMEOUT_CYC < 3) begin : g_bad_params
    $error("hc05_cmd_parser: CLK_FREQ must be positive and TIMEOUT_CYC at least 3");
  end

  hc05_state_t r_state;
  hc05_state_t w_state_nxt;

  logic [7:0] r_cmd_sh;
  logic [7:0] r_arg_sh;
  logic [7:0] r_cmd_code;
  logic [7:0] r_cmd_arg;
  logic       r_cmd_valid;
  logic       r_err_pulse;
  logic [1:0] r_err_code;
  logic [7:0] r_frame_cnt;

  logic       w_tmo;
  logic       w_good;
  logic       w_err;
  logic [1:0] w_err_code;
  logic       w_ld_cmd;
  logic       w_ld_arg;

  hc05_byte_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .i_clr (rx_vld),
    .i_en  (r_state != IDLE),
    .o_tc  (w_tmo)
  );

  // w_tmo is already masked by rx_vld, so a byte on the terminal cycle wins.
  always_comb begin
    w_state_nxt = r_state;
    w_good      = 1'b0;
    w_err       = 1'b0;
    w_err_code  = ERR_NONE;
    w_ld_cmd    = 1'b0;
    w_ld_arg    = 1'b0;
    if (w_tmo) begin
      w_state_nxt = IDLE;
      w_err       = 1'b1;
      w_err_code  = ERR_TMO;
    end else if (rx_vld) begin
      case (r_state)
        IDLE: begin
          if (rx_data == HDR_BYTE) w_state_nxt = GET_CMD;
        end
        GET_CMD: begin
          w_ld_cmd    = 1'b1;
          w_state_nxt = GET_ARG;
        end
        GET_ARG: begin
          w_ld_arg    = 1'b1;
          w_state_nxt = GET_CHK;
        end
        GET_CHK: begin
          if (rx_data == (r_cmd_sh ^ r_arg_sh)) begin
            w_state_nxt = GET_TAIL;
          end else begin
            w_state_nxt = IDLE;
            w_err       = 1'b1;
            w_err_code  = ERR_CHK;
          end
        end
        GET_TAIL: begin
          w_state_nxt = IDLE;
          if (rx_data == TAIL_BYTE) begin
            w_good = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_err_code = ERR_TAIL;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd_sh <= '0;
      r_arg_sh <= '0;
    end else begin
      if (w_ld_cmd) r_cmd_sh <= rx_data;
      if (w_ld_arg) r_arg_sh <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd_code  <= '0;
      r_cmd_arg   <= '0;
      r_cmd_valid <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_frame_cnt <= '0;
    end else begin
      r_cmd_valid <= w_good;
      r_err_pulse <= w_err;
      if (w_err) r_err_code <= w_err_code;
      if (w_good) begin
        r_cmd_code  <= r_cmd_sh;
        r_cmd_arg   <= r_arg_sh;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign cmd_code  = r_cmd_code;
  assign cmd_arg   = r_cmd_arg;
  assign cmd_valid = r_cmd_valid;
  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;
  assign frame_cnt = r_frame_cnt;

`ifdef HC05_CMD_PARSER_ACK_EN
  logic [7:0] r_ack_data;
  logic       r_ack_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack_data <= '0;
      r_ack_vld  <= 1'b0;
    end else begin
      r_ack_vld <= w_good || w_err;
      if (w_good) begin
        r_ack_data <= r_cmd_sh ^ ACK_XOR_MASK;
      end else if (w_err) begin
        r_ack_data <= {ACK_ERR_PREFIX, w_err_code};
      end
    end
  end

  assign ack_data = r_ack_data;
  assign ack_vld  = r_ack_vld;
`else
  assign ack_data = 8'd0;
  assign ack_vld  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hc05_cmd_parser.sv
// tb_hc05_cmd_parser: directed frames with a queue-based scoreboard for hc05_cmd_parser.
`default_nettype none

module tb_hc05_cmd_parser;

  localparam int TMO = 200;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic [7:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       cmd_valid;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] frame_cnt;
  logic [7:0] ack_data;
  logic       ack_vld;

  hc05_cmd_parser #(
    .CLK_FREQ    (24000000),
    .TIMEOUT_CYC (TMO),
    .HDR_BYTE    (8'hA5),
    .TAIL_BYTE   (8'h5A)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_vld    (rx_vld),
    .cmd_code  (cmd_code),
    .cmd_arg   (cmd_arg),
    .cmd_valid (cmd_valid),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .frame_cnt (frame_cnt),
    .ack_data  (ack_data),
    .ack_vld   (ack_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         good;
    int         cyc;
    logic [7:0] code;
    logic [7:0] arg;
    logic [7:0] cnt;
    logic [1:0] ec;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_good = 0;

  logic [7:0] m_code = 8'd0;
  logic [7:0] m_arg  = 8'd0;
  logic [7:0] m_cnt  = 8'd0;
  logic [1:0] m_ec   = 2'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_good(input int c, input logic [7:0] cd, input logic [7:0] ar);
    exp_t e;
    m_code = cd;
    m_arg  = ar;
    m_cnt  = m_cnt + 8'd1;
    e.good = 1'b1; e.cyc = c; e.code = cd; e.arg = ar; e.cnt = m_cnt; e.ec = m_ec;
    q.push_back(e);
  endtask

  task automatic exp_err(input int c, input logic [1:0] ec);
    exp_t e;
    m_ec   = ec;
    e.good = 1'b0; e.cyc = c; e.code = m_code; e.arg = m_arg; e.cnt = m_cnt; e.ec = ec;
    q.push_back(e);
  endtask

  // Returns the cycle index of the edge that sampled the strobe.
  task automatic send_byte(input logic [7:0] b, input int gap, output int s);
    repeat (gap) @(posedge clk);
    #1;
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk);
    #1;
    rx_vld = 1'b0;
    s      = cyc;
  endtask

  // kind: 0 good frame, 1 checksum error on byte 4, 2 tail error on byte 5.
  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4,
                       input int gap0, input int gap, input int kind);
    logic [7:0] b [5];
    int s;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
    for (int i = 0; i < 5; i++) begin
      send_byte(b[i], (i == 0) ? gap0 : gap, s);
      if (kind == 1 && i == 3) exp_err(s, 2'd1);
      if (i == 4) begin
        if (kind == 0) exp_good(s, b[1], b[2]);
        else if (kind == 2) exp_err(s, 2'd2);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_code"},  cmd_code,  0);
    chk({tag, "_cmd_arg"},   cmd_arg,   0);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_err_pulse"}, err_pulse, 0);
    chk({tag, "_err_code"},  err_code,  0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_ack_vld"},   ack_vld,   0);
    chk({tag, "_ack_data"},  ack_data,  0);
  endtask

  always @(negedge clk) begin
    if (reset && (cmd_valid || err_pulse)) begin
      if (cmd_valid) n_good++;
      if (cmd_valid && err_pulse) begin
        chk("valid_and_err_together", 1, 0);
      end else if (q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_event: cmd_valid=%0b err_pulse=%0b err_code=%0d, expected no event (cycle %0d)",
                 cmd_valid, err_pulse, err_code, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_kind",  cmd_valid, e.good);
        chk("event_cycle", cyc,       e.cyc);
        chk("cmd_code",    cmd_code,  e.code);
        chk("cmd_arg",     cmd_arg,   e.arg);
        chk("frame_cnt",   frame_cnt, e.cnt);
        chk("err_code",    err_code,  e.ec);
`ifdef HC05_CMD_PARSER_ACK_EN
        chk("ack_vld", ack_vld, 1);
        chk("ack_data", ack_data, e.good ? (e.code ^ 8'h80) : {6'b111011, e.ec});
`else
        chk("ack_vld_off", ack_vld, 0);
        chk("ack_data_off", ack_data, 0);
`endif
      end
    end else if (reset && ack_vld) begin
      chk("ack_without_event", ack_vld, 0);
    end
  end

  initial begin
    int s;
    int s2;
    int g0;
    int w;
    reset   = 1'b0;
    rx_vld  = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("reset");

    // Good frame, 100-cycle byte spacing.
    frame(8'hA5, 8'h01, 8'h03, 8'h02, 8'h5A, 100, 100, 0);
    // Bad checksum; trailing tail byte must be ignored.
    frame(8'hA5, 8'h01, 8'h03, 8'h07, 8'h5A, 5, 3, 1);
    // Bad tail then a header right in the following cycle.
    frame(8'hA5, 8'h02, 8'h04, 8'h06, 8'h00, 5, 3, 2);
    frame(8'hA5, 8'h02, 8'h04, 8'h06, 8'h5A, 0, 3, 0);

    // Timeout after A5 03.
    send_byte(8'hA5, 5, s);
    send_byte(8'h03, 2, s);
    exp_err(s + TMO - 1, 2'd3);
    repeat (TMO + 10) @(posedge clk);

    // A byte on the terminal cycle suppresses the timeout.
    send_byte(8'hA5, 2, s);
    send_byte(8'h03, 2, s);
    repeat (TMO - 2) @(posedge clk);
    send_byte(8'h06, 0, s2);
    send_byte(8'h05, 2, s);
    send_byte(8'h5A, 2, s);
    exp_good(s, 8'h03, 8'h06);
    repeat (5) @(posedge clk);

    // Reset in the middle of A5 01 03.
    send_byte(8'hA5, 2, s);
    send_byte(8'h01, 2, s);
    send_byte(8'h03, 2, s);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    m_code = 8'd0; m_arg = 8'd0; m_cnt = 8'd0; m_ec = 2'd0;
    @(posedge clk);
    #3 reset = 1'b1;
    send_byte(8'h02, 2, s);
    send_byte(8'h5A, 2, s);
    repeat (TMO + 10) @(posedge clk);
    #1;
    chk("post_reset_frame_cnt", frame_cnt, 0);

    // 256 good frames: counter wraps back to 0.
    g0 = n_good;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      logic [7:0] a;
      c = 8'(i);
      a = 8'(i * 7 + 1);
      frame(8'hA5, c, a, c ^ a, 8'h5A, 1, 1, 0);
    end

    w = 0;
    while (q.size() != 0 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: %0d events still pending, expected 0", q.size());
    end
    repeat (20) @(posedge clk);
    #1;
    chk("wrap_frame_cnt", frame_cnt, 0);
    chk("wrap_valid_pulses", n_good - g0, 256);
    chk("wrap_last_code", cmd_code, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
